duc_core: RTL

DUC_CORE -- requirements
Module: duc_core

---
 rtl/duc_core_if.sv | 21 ++
 rtl/duc_core.sv | 103 ++++++++++
 2 files changed

// File: rtl/duc_core_if.sv
// Stream bundle for duc_core: baseband in, DDS in (no backpressure), DAC out.
interface duc_core_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_dds_tdata;
  logic        s_axis_dds_tvalid;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_dds_tdata, s_axis_dds_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_dds_tdata, s_axis_dds_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/duc_core.sv
// Digital upconverter mixer: out = sat(round((I*cos - Q*sin) >> OUT_SHIFT)), 4-cycle latency.
// Whole pipeline stalls while the output is held; the DDS stream is dropped when not accepted.
module duc_core #(
  parameter int OUT_SHIFT = 13
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  duc_core_if.slave   axis,
  input  logic        sat_clear,
  output logic [15:0] sat_count
);

  localparam logic signed [31:0] RND = 32'sd1 <<< (OUT_SHIFT - 1);

  logic en, fire;

  logic                v1_q, v2_q, v3_q, v4_q;
  logic signed [15:0]  i_q, q_q, i_d, q_d;
  logic signed [13:0]  cos_q, sin_q, cos_d, sin_d;
  logic signed [29:0]  ic_q, qs_q, ic_d, qs_d;
  logic signed [30:0]  diff_q, diff_d;
  logic signed [15:0]  out_q, out_d;
  logic [15:0]         sat_q, sat_d;
  logic signed [31:0]  sum, shifted;
  logic                sat_hit;
  logic                unused_dds_bits;

  assign en    = !v4_q || axis.m_axis_tready;
  assign fire  = axis.s_axis_tvalid && axis.s_axis_dds_tvalid && en;

  assign axis.s_axis_tready = en;
  assign axis.m_axis_tdata  = out_q;
  assign axis.m_axis_tvalid = v4_q;
  assign sat_count          = sat_q;

  assign unused_dds_bits = ^{axis.s_axis_dds_tdata[31:30], axis.s_axis_dds_tdata[15:14]};

  always_comb begin
    i_d     = axis.s_axis_tdata[15:0];
    q_d     = axis.s_axis_tdata[31:16];
    cos_d   = axis.s_axis_dds_tdata[13:0];
    sin_d   = axis.s_axis_dds_tdata[29:16];
    ic_d    = i_q * cos_q;
    qs_d    = q_q * sin_q;
    diff_d  = $signed({ic_q[29], ic_q}) - $signed({qs_q[29], qs_q});
    sum     = $signed({diff_q[30], diff_q}) + RND;
    shifted = sum >>> OUT_SHIFT;
    sat_hit = 1'b0;
    out_d   = shifted[15:0];
    if (shifted > 32'sd32767) begin
      out_d   = 16'sh7fff;
      sat_hit = 1'b1;
    end else if (shifted < -32'sd32768) begin
      out_d   = 16'sh8000;
      sat_hit = 1'b1;
    end
  end

  // Counter saturates at all-ones; clear wins over a same-cycle increment.
  always_comb begin
    sat_d = sat_q;
    if (sat_clear) begin
      sat_d = 16'd0;
    end else if (en && v3_q && sat_hit && (sat_q != 16'hffff)) begin
      sat_d = sat_q + 16'd1;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      v4_q   <= 1'b0;
      i_q    <= '0;
      q_q    <= '0;
      cos_q  <= '0;
      sin_q  <= '0;
      ic_q   <= '0;
      qs_q   <= '0;
      diff_q <= '0;
      out_q  <= '0;
      sat_q  <= '0;
    end else begin
      sat_q <= sat_d;
      if (en) begin
        v1_q   <= fire;
        v2_q   <= v1_q;
        v3_q   <= v2_q;
        v4_q   <= v3_q;
        i_q    <= i_d;
        q_q    <= q_d;
        cos_q  <= cos_d;
        sin_q  <= sin_d;
        ic_q   <= ic_d;
        qs_q   <= qs_d;
        diff_q <= diff_d;
        out_q  <= out_d;
      end
    end
  end

endmodule
